// File: rtl/alu_seq_if.sv
// Request/result channel between an ALU client and the alu_seq operand sequencer.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_wide;
  logic        req_use_c;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic [15:0] res_data;

  modport master (
    output req_valid, req_op, req_wide, req_use_c, req_a, req_b,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_op, req_wide, req_use_c, req_a, req_b,
    output req_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_seq.sv
// Operand sequencer and status latch: feeds the ALU one byte per cycle (low first,
// carry chained) and holds the last result plus C/Z/N/V flags for branch logic.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   req,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_cins,
  output logic       alu_oe,
  output logic       alu_cin,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_vout,
  input  logic       flags_clr,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_next;

  logic [2:0]  op_q;
  logic        wide_q;
  logic        use_c_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] acc_q;
  logic        cl_q;
  logic        c_last_q;
  logic        v_last_q;
  logic [15:0] res_q;
  logic        fc_q, fz_q, fn_q, fv_q;

  logic        done;
  logic        fresh_z;
  logic        fresh_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req.req_valid) state_next = LO;
      LO:      state_next = wide_q ? HI : DONE;
      HI:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = 1'b0;
    req.res_valid = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_oe        = 1'b0;
    alu_cin       = 1'b0;
    alu_cins      = {5'b0, op_q};
    unique case (state)
      IDLE: req.req_ready = 1'b1;
      LO: begin
        alu_a   = a_q[7:0];
        alu_b   = b_q[7:0];
        alu_oe  = 1'b1;
        alu_cin = use_c_q & fc_q;
      end
      HI: begin
        alu_a   = a_q[15:8];
        alu_b   = b_q[15:8];
        alu_oe  = 1'b1;
        alu_cin = cl_q;
      end
      DONE:    req.res_valid = 1'b1;
      default: ;
    endcase
  end

  // In DONE the outputs show the freshly assembled result so they are valid
  // alongside res_valid; the same values are registered at the end of DONE.
  assign done    = (state == DONE);
  assign fresh_z = (acc_q == 16'h0000);
  assign fresh_n = wide_q ? acc_q[15] : acc_q[7];

  always_comb begin
    req.res_data = done ? acc_q : res_q;
    flag_c       = done ? (~flags_clr & c_last_q) : fc_q;
    flag_z       = done ? (~flags_clr & fresh_z)  : fz_q;
    flag_n       = done ? (~flags_clr & fresh_n)  : fn_q;
    flag_v       = done ? (~flags_clr & v_last_q) : fv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      wide_q   <= 1'b0;
      use_c_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cl_q     <= 1'b0;
      c_last_q <= 1'b0;
      v_last_q <= 1'b0;
      res_q    <= '0;
      fc_q     <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req.req_valid) begin
            op_q    <= req.req_op;
            wide_q  <= req.req_wide;
            use_c_q <= req.req_use_c;
            a_q     <= req.req_a;
            b_q     <= req.req_b;
            acc_q   <= '0;
          end
        end
        LO: begin
          acc_q[7:0] <= alu_res;
          cl_q       <= alu_cout;
          c_last_q   <= alu_cout;
          v_last_q   <= alu_vout;
        end
        HI: begin
          acc_q[15:8] <= alu_res;
          c_last_q    <= alu_cout;
          v_last_q    <= alu_vout;
        end
        DONE: begin
          res_q <= acc_q;
          fc_q  <= c_last_q;
          fz_q  <= fresh_z;
          fn_q  <= fresh_n;
          fv_q  <= v_last_q;
        end
        default: ;
      endcase
      // Clear overrides any flag update made in the same cycle.
      if (flags_clr) begin
        fc_q <= 1'b0;
        fz_q <= 1'b0;
        fn_q <= 1'b0;
        fv_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Operand sequencer and status latch sitting directly upstream of the ALU. It accepts an operation request over a valid/ready handshake and latches the 8- or 16-bit operands. It drives the ALU one byte per cycle, low byte first, chaining the carry between bytes, and captures the ALU result. It holds the C/Z/N/V status flags that the branch logic consumes.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  3  ALU operation code; ALU select = {5'b0, req_op}
- req_wide  in  1  1 = 16-bit operation (two ALU passes), 0 = 8-bit
- req_use_c  in  1  1 = low-byte carry-in taken from flag_c
- req_a  in  16  operand A (bits 15:8 ignored when req_wide=0)
- req_b  in  16  operand B (bits 15:8 ignored when req_wide=0)
- alu_a  out  8  ALU operand A byte
- alu_b  out  8  ALU operand B byte
- alu_cins  out  8  ALU operation select
- alu_oe  out  1  ALU output enable
- alu_cin  out  1  ALU carry-in
- alu_res  in  8  ALU result byte
- alu_cout  in  1  ALU carry-out
- alu_vout  in  1  ALU signed overflow
- res_valid  out  1  one-cycle pulse: res_data and flags freshly updated
- res_data  out  16  last result; high byte 0 for 8-bit ops
- flags_clr  in  1  synchronous clear of all four flags
- flag_c, flag_z, flag_n, flag_v  out  1 each  carry, zero, negative, overflow

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, wide, use_c and operands, then go to LO.
- LO:
  - alu_a=A[7:0], alu_b=B[7:0], alu_oe=1, alu_cin=use_c & flag_c.
  - Capture alu_res into the result low byte.
  - Capture alu_cout into internal carry register cl, and alu_vout.
  - Next state is HI if wide, else DONE.
- HI:
  - alu_a=A[15:8], alu_b=B[15:8], alu_oe=1, alu_cin=cl.
  - Capture the result high byte, alu_cout and alu_vout. Go to DONE.
- DONE:
  - res_valid=1.
  - res_data, flag_c and flag_v take the values captured in the last ALU pass.
  - flag_z = (16-bit result == 0).
  - flag_n = bit 15 if wide, else bit 7.
  - Go to IDLE.
- Outside LO/HI: alu_a=alu_b=0, alu_oe=0, alu_cin=0, alu_cins holds the last latched op.
- req_ready=0 in LO, HI and DONE; requests presented then are not accepted and must be held by the requester.
- res_data and flags hold between operations.
- Flag update precedence: flags_clr wins over a flag update in the same cycle. res_data still updates and res_valid still pulses.
- flags_clr during LO with use_c=1: alu_cin uses the flag value registered at the start of that cycle.

## Timing
- Reset values: state IDLE, req_ready=1, res_valid=0, res_data=0, all flags 0, alu_* outputs 0, cl=0.
- Handshake: a request is accepted at the edge where req_valid & req_ready.
- 8-bit latency: accept at edge 0; LO is cycle 1; res_valid is high in cycle 2 (DONE); req_ready returns in cycle 3.
- 16-bit latency: LO cycle 1, HI cycle 2, res_valid cycle 3, req_ready cycle 4.
- Throughput: one 8-bit op per 3 cycles, one 16-bit op per 4 cycles.
- The ALU is combinational. Its inputs are driven from registers, and its outputs are sampled at the end of the same cycle.
- Reset mid-operation (any state) aborts immediately:
  - no res_valid;
  - flags and res_data return to 0;
  - the op is not retried.
- req_valid asserted in the same cycle as reset release is not accepted until the first edge after release.

## Test plan
- Reset with all inputs toggling -> every output at its reset value, req_ready=1.
- 8-bit add, A=0x7F, B=0x01, use_c=0 -> LO drives alu_a=0x7F, alu_b=0x01, alu_cin=0; res_data=0x0080, V=1, N=1, Z=0, C=0; res_valid in cycle 2 only.
- 16-bit add, A=0x00FF, B=0x0001 -> HI pass has alu_cin=1; res_data=0x0100, C=0, Z=0, N=0; res_valid in cycle 3.
- 16-bit add, A=0xFFFF, B=0x0001 -> res_data=0x0000, Z=1, C=1. Then an 8-bit add with use_c=1, A=0x00, B=0x00 -> LO alu_cin=1, res_data=0x0001, C=0.
- req_valid held high back-to-back -> second request accepted only in the first IDLE cycle after DONE; no request lost or duplicated.
- flags_clr coincident with DONE -> flags all 0, res_data updated, res_valid=1. Then rst asserted during HI -> no res_valid, all outputs at reset values.
